// File: rtl/uart_rx_if.sv
// UART receiver signal bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a synchronised copy of the line.
// Registered outputs; synchronous active-high reset.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.slave  rx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                dv_q, dv_d;
  logic                act_q, act_d;
  logic                ferr_q, ferr_d;
  logic                sync1_q;
  logic                rx_s;

  // State, datapath and synchroniser registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      act_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx.i_Rx_Serial;
      rx_s    <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      act_q   <= act_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and next-output logic; the counter clears on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    act_d   = act_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = START;
          act_d   = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            act_d   = 1'b0;
          end
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_W'(7)) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          act_d   = 1'b0;
          state_d = CLEANUP;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      CLEANUP: begin
        // A held-low line (break) waits here rather than starting a false frame
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx.o_Rx_DV        = dv_q;
  assign rx.o_Rx_Byte      = byte_q;
  assign rx.o_Rx_Active    = act_q;
  assign rx.o_Rx_Frame_Err = ferr_q;

endmodule
